// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity encodings and timing helpers.
// Imported by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 8;
    localparam int BIT_IDX_W     = 3;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even parity makes the total count of ones (data plus parity bit) even.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int data_bits,
                                         input int parity);
        logic x;
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < data_bits) begin
                x = x ^ data[i];
            end
        end
        return (parity == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_end
// on the final count. Shared between the UART transmitter and receiver.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             bit_end
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end = enable && !clear && (count_q == CNT_W'(CLKS_PER_BIT - 1));
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = bit_end ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it
// as start, LSB-first data, optional parity and one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    uart_state_e              state_q, state_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic                     par_q, par_d;
    logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;

    logic                     baud_clear;
    logic                     baud_en;
    logic                     bit_end;
    logic                     last_cycle;
    logic [CNT_W-1:0]         baud_count;
    logic [MAX_DATA_BITS-1:0] data_ext;

    assign baud_clear = (state_q == ST_IDLE);
    assign baud_en    = (state_q != ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .enable (baud_en),
        .count  (baud_count),
        .bit_end(bit_end)
    );

    // tx_done is registered, so it is raised one cycle early to land on the last stop cycle.
    assign last_cycle = (baud_count == CNT_W'(CLKS_PER_BIT - 2));

    assign tx_ready = (state_q == ST_IDLE) && !reset;
    assign tx_busy  = (state_q != ST_IDLE);
    assign TX       = tx_q;
    assign tx_done  = done_q;

    always_comb begin
        data_ext                   = '0;
        data_ext[DATA_BITS-1:0]    = tx_data;
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    shift_d   = tx_data;
                    par_d     = calc_parity(data_ext, DATA_BITS, PARITY);
                    bit_idx_d = '0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end

            ST_STOP: begin
                tx_d   = 1'b1;
                done_d = last_cycle && (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1));
                if (bit_end) begin
                    if (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised testbench for uart_tx: four instances with different frame formats,
// compared cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NDUT = 4;

    logic            clk;
    logic            reset;
    logic [7:0]      tx_data [NDUT];
    logic [NDUT-1:0] tx_valid;
    wire  [NDUT-1:0] tx_ready;
    wire  [NDUT-1:0] tx_line;
    wire  [NDUT-1:0] tx_busy;
    wire  [NDUT-1:0] tx_done;

    int total = 0;
    int bad   = 0;

    // Per-cycle samples packed as {ready, done, busy, tx}.
    logic [3:0] obs_q[$];
    logic [3:0] exp_q[$];

    // Instance 0 derives its bit period from CLK_FREQ/BAUD (100 MHz / 25 MBd = 4).
    uart_tx #(.CLK_FREQ(100_000_000), .BAUD(25_000_000)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .TX(tx_line[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

    uart_tx #(.CLKS_PER_BIT(3), .PARITY(2)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .TX(tx_line[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

    uart_tx #(.CLKS_PER_BIT(3), .PARITY(1)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .TX(tx_line[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

    uart_tx #(.CLKS_PER_BIT(5), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .TX(tx_line[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cpb_of(input int k);
        case (k)
            0:       return 4;
            1, 2:    return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int parity_of(input int k);
        case (k)
            1:       return PAR_EVEN;
            2:       return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic int stops_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return (1 + 8 + ((parity_of(k) != PAR_NONE) ? 1 : 0) + stops_of(k)) * cpb_of(k);
    endfunction

    // Reference frame: list of line levels, each held for one bit period.
    task automatic model_frame(input int k, input logic [7:0] d);
        int bits[$];
        int ones;
        int n;
        ones = $countones(d);
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
        if (parity_of(k) == PAR_EVEN) bits.push_back(ones % 2);
        else if (parity_of(k) == PAR_ODD) bits.push_back(1 - ones % 2);
        for (int s = 0; s < stops_of(k); s++) bits.push_back(1);
        n = bits.size() * cpb_of(k);
        for (int c = 0; c < n; c++) begin
            exp_q.push_back({1'b0, (c == n - 1), 1'b1, bits[c / cpb_of(k)][0]});
        end
    endtask

    task automatic model_idle(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(4'b1001);
    endtask

    task automatic capture(input int k, input int n);
        obs_q = {};
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs_q.push_back({tx_ready[k], tx_done[k], tx_busy[k], tx_line[k]});
        end
    endtask

    function automatic int first_diff(input logic [3:0] a[$], input logic [3:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (tx_ready[k] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = '1;
        for (int k = 0; k < NDUT; k++) tx_data[k] = 8'($urandom);
        repeat (2) @(negedge clk);
        total++;
        if (tx_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready: got %b want 0000", tx_ready);
        end
        total++;
        if ({tx_line, tx_busy, tx_done} !== 12'hF00) begin
            bad++; $display("FAIL reset_outputs: got line/busy/done=%h want f00", {tx_line, tx_busy, tx_done});
        end
        tx_valid = '0;
        reset    = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_ready, tx_line, tx_busy, tx_done} !== 16'hFF00) begin
            bad++; $display("FAIL idle_after_reset: got ready/line/busy/done=%h want ff00",
                            {tx_ready, tx_line, tx_busy, tx_done});
        end
        total++;
        if (calc_clks_per_bit(100_000_000, 9600) != 10416) begin
            bad++; $display("FAIL default_cpb: got %0d want 10416", calc_clks_per_bit(100_000_000, 9600));
        end
    endtask

    task automatic test_frame_8n1();
        logic [7:0] d;
        logic [9:0] got;
        logic [9:0] want;
        bit ok;
        int i;
        for (int j = 0; j < 4; j++) begin
            d = (j == 0) ? 8'h32 : 8'($urandom);
            wait_ready(0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL frame_ready: got tx_ready=0 want 1"); end
            tx_valid[0] = 1'b1;
            tx_data[0]  = d;
            exp_q = {};
            model_frame(0, d);
            model_idle(2);
            fork
                capture(0, exp_q.size());
                begin
                    @(negedge clk);
                    tx_valid[0] = 1'b0;
                    tx_data[0]  = 8'($urandom);
                end
            join
            total++;
            i = first_diff(obs_q, exp_q);
            if (i >= 0) begin
                bad++; $display("FAIL frame_8n1 byte %h cycle %0d: got rdy/done/busy/tx=%b want %b",
                                d, i, obs_q[i], exp_q[i]);
            end
            if (j == 0) begin
                for (int b = 0; b < 10; b++) got[b] = obs_q[b * 4 + 2][0];
                want = 10'b1001100100;
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL pattern_32: got %b want %b (bit0 first = rightmost)", got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        bit ok;
        int i;
        for (int j = 0; j < 2; j++) begin
            a = (j == 0) ? 8'hA5 : 8'($urandom);
            b = (j == 0) ? 8'h3C : 8'($urandom);
            wait_ready(0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL b2b_ready: got tx_ready=0 want 1"); end
            tx_valid[0] = 1'b1;
            tx_data[0]  = a;
            exp_q = {};
            model_frame(0, a);
            model_idle(1);
            model_frame(0, b);
            model_idle(2);
            fork
                capture(0, exp_q.size());
                begin
                    @(negedge clk);
                    tx_data[0] = b;
                    repeat (frame_len(0) + 3) @(negedge clk);
                    tx_valid[0] = 1'b0;
                    tx_data[0]  = 8'($urandom);
                end
            join
            total++;
            i = first_diff(obs_q, exp_q);
            if (i >= 0) begin
                bad++; $display("FAIL back_to_back %h,%h cycle %0d: got rdy/done/busy/tx=%b want %b",
                                a, b, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        bit ok;
        int i;
        int busy_cnt;
        for (int k = 1; k <= 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                d = (j == 0) ? 8'h07 : 8'($urandom);
                wait_ready(k, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL parity_ready dut%0d: got tx_ready=0 want 1", k); end
                tx_valid[k] = 1'b1;
                tx_data[k]  = d;
                exp_q = {};
                model_frame(k, d);
                model_idle(2);
                fork
                    capture(k, exp_q.size());
                    begin
                        @(negedge clk);
                        tx_valid[k] = 1'b0;
                        tx_data[k]  = 8'($urandom);
                    end
                join
                total++;
                i = first_diff(obs_q, exp_q);
                if (i >= 0) begin
                    bad++; $display("FAIL parity_frame dut%0d byte %h cycle %0d: got %b want %b",
                                    k, d, i, obs_q[i], exp_q[i]);
                end
                if (j == 0) begin
                    total++;
                    if (obs_q[9 * 3 + 1][0] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                        bad++; $display("FAIL parity_bit_07 dut%0d: got %b want %b",
                                        k, obs_q[9 * 3 + 1][0], (k == 1) ? 1'b1 : 1'b0);
                    end
                    busy_cnt = 0;
                    foreach (obs_q[c]) if (obs_q[c][1] === 1'b1) busy_cnt++;
                    total++;
                    if (busy_cnt != 33) begin
                        bad++; $display("FAIL parity_len dut%0d: got %0d busy cycles want 33", k, busy_cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_two_stop();
        logic [7:0] d;
        bit ok;
        int i;
        int zeros;
        int done_at;
        for (int j = 0; j < 3; j++) begin
            d = (j == 0) ? 8'hFF : 8'($urandom);
            wait_ready(3, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL stop2_ready: got tx_ready=0 want 1"); end
            tx_valid[3] = 1'b1;
            tx_data[3]  = d;
            exp_q = {};
            model_frame(3, d);
            model_idle(2);
            fork
                capture(3, exp_q.size());
                begin
                    @(negedge clk);
                    tx_valid[3] = 1'b0;
                    tx_data[3]  = 8'($urandom);
                end
            join
            total++;
            i = first_diff(obs_q, exp_q);
            if (i >= 0) begin
                bad++; $display("FAIL stop2_frame byte %h cycle %0d: got %b want %b", d, i, obs_q[i], exp_q[i]);
            end
            if (j == 0) begin
                zeros   = 0;
                done_at = -1;
                foreach (obs_q[c]) begin
                    if (obs_q[c][0] === 1'b0) zeros++;
                    if (obs_q[c][2] === 1'b1 && done_at < 0) done_at = c;
                end
                total++;
                if (zeros != 5) begin
                    bad++; $display("FAIL stop2_low_cycles: got %0d want 5", zeros);
                end
                total++;
                if (done_at != 54) begin
                    bad++; $display("FAIL stop2_done_cycle: got %0d want 54", done_at);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        bit ok;
        int i;
        wait_ready(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_ready: got tx_ready=0 want 1"); end
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h55;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (tx_line[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_data_bit1: got %b want 0", tx_line[0]);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({tx_ready[0], tx_busy[0], tx_line[0]} !== 3'b001) begin
            bad++; $display("FAIL midrst_async: got ready/busy/tx=%b want 001", {tx_ready[0], tx_busy[0], tx_line[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_ready[0], tx_busy[0], tx_line[0]} !== 3'b101) begin
            bad++; $display("FAIL midrst_release: got ready/busy/tx=%b want 101", {tx_ready[0], tx_busy[0], tx_line[0]});
        end
        d = 8'($urandom);
        tx_valid[0] = 1'b1;
        tx_data[0]  = d;
        exp_q = {};
        model_frame(0, d);
        model_idle(2);
        fork
            capture(0, exp_q.size());
            begin
                @(negedge clk);
                tx_valid[0] = 1'b0;
            end
        join
        total++;
        i = first_diff(obs_q, exp_q);
        if (i >= 0) begin
            bad++; $display("FAIL midrst_recover byte %h cycle %0d: got %b want %b", d, i, obs_q[i], exp_q[i]);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] sent [3];
        logic [7:0] got[$];
        logic [7:0] r;
        int frame_err;
        int cpb;
        int len;
        bit found;
        bit ok;
        sent      = '{8'h32, 8'h31, 8'h64};
        cpb       = cpb_of(0);
        len       = frame_len(0);
        frame_err = 0;
        got       = {};
        wait_ready(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL loop_ready: got tx_ready=0 want 1"); end
        tx_valid[0] = 1'b1;
        tx_data[0]  = sent[0];
        fork
            begin
                @(negedge clk);
                tx_data[0] = sent[1];
                repeat (len + 1) @(negedge clk);
                tx_data[0] = sent[2];
                repeat (len + 1) @(negedge clk);
                tx_valid[0] = 1'b0;
            end
            begin
                for (int n = 0; n < 3; n++) begin
                    found = 1'b0;
                    for (int c = 0; c < 4 * len && !found; c++) begin
                        @(negedge clk);
                        if (tx_line[0] === 1'b0) found = 1'b1;
                    end
                    if (!found) break;
                    repeat (cpb / 2) @(negedge clk);
                    if (tx_line[0] !== 1'b0) frame_err++;
                    for (int b = 0; b < 8; b++) begin
                        repeat (cpb) @(negedge clk);
                        r[b] = tx_line[0];
                    end
                    repeat (cpb) @(negedge clk);
                    if (tx_line[0] !== 1'b1) frame_err++;
                    got.push_back(r);
                end
            end
        join
        total++;
        if (got.size() != 3) begin
            bad++; $display("FAIL loop_count: got %0d bytes want 3", got.size());
        end
        for (int n = 0; n < got.size(); n++) begin
            total++;
            if (got[n] !== sent[n]) begin
                bad++; $display("FAIL loop_byte%0d: got %h want %h", n, got[n], sent[n]);
            end
        end
        total++;
        if (frame_err != 0) begin
            bad++; $display("FAIL loop_framing: got %0d framing errors want 0", frame_err);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        tx_valid = '0;
        for (int k = 0; k < NDUT; k++) tx_data[k] = 8'h00;
        reset = 1'b1;
        test_reset();
        test_frame_8n1();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_reset_mid_frame();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
